// File: rtl/mp3_decoder_top.sv
// Granule sequencer (Huffman core then synthesis MAC) plus stereo PCM ring buffer and sample-rate playout.
// Latency: MAC sample to buffer write strobe 1 cycle; sample_clk edge to pcm_strobe/underrun 3 cycles.
// Backpressure: none on MAC_valid; a granule only starts when the buffer has room for all of its samples.
module mp3_decoder_top #(
    parameter int PCM_DEPTH  = 2048,
    parameter int GR_SAMPLES = 576,
    localparam int AW = $clog2(PCM_DEPTH)
) (
    input  logic               MASTER_CLOCK_I,
    input  logic               global_rst_n,
    input  logic               AC97_BIT_CLOCK_I,
    input  logic               module_en,
    input  logic               sample_clk,
    output logic               HUFF_start,
    input  logic               HUFF_done,
    output logic               MAC_start,
    input  logic               MAC_valid,
    input  logic signed [15:0] MAC_ch0_data,
    input  logic signed [15:0] MAC_ch1_data,
    output logic               CH0_PCM_RAM_we,
    output logic [15:0]        CH0_PCM_RAM_write_data,
    output logic [15:0]        CH1_PCM_RAM_write_data,
    output logic [AW-1:0]      PCM_RAM_address,
    output logic signed [15:0] pcm_left,
    output logic signed [15:0] pcm_right,
    output logic               pcm_strobe,
    output logic               underrun,
    output logic [15:0]        frame_count
);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(GR_SAMPLES);
    localparam logic [CW-1:0] START_MAX   = CW'(PCM_DEPTH - GR_SAMPLES);
    localparam logic [SW-1:0] LAST_SAMPLE = SW'(GR_SAMPLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HSTART,
        ST_HWAIT_LO,
        ST_HWAIT_HI,
        ST_MSTART,
        ST_MWAIT
    } state_t;

    // The MAC stage and the sequencer share the master clock; the AC97 bit clock is the same
    // source and deliberately drives nothing here.
    logic MAC_clock;
    logic unused_bit_clk;
    assign MAC_clock      = MASTER_CLOCK_I;
    assign unused_bit_clk = AC97_BIT_CLOCK_I;

    state_t        state, state_nxt;
    logic [SW-1:0] smp_cnt;
    logic          gr;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_pend;
    logic [31:0]   pcm_mem [PCM_DEPTH];
    logic          s_meta, s_sync, s_prev;
    logic          tick, rd_fire, accept, last_accept, room;

    assign accept      = (state == ST_MWAIT) && MAC_valid;
    assign last_accept = accept && (smp_cnt == LAST_SAMPLE);
    // Include the write still in flight so the room test is never optimistic.
    assign count_pend  = count + {{AW{1'b0}}, CH0_PCM_RAM_we};
    assign room        = (count_pend <= START_MAX);
    assign tick        = s_sync && !s_prev;
    assign rd_fire     = tick && (count != '0);

    // Sequencer state register.
    always_ff @(posedge MAC_clock or negedge global_rst_n) begin
        if (!global_rst_n) state <= ST_IDLE;
        else               state <= state_nxt;
    end

    // Sequencer next state and start pulses.
    always_comb begin
        state_nxt  = state;
        HUFF_start = 1'b0;
        MAC_start  = 1'b0;
        case (state)
            ST_IDLE:     if (module_en && room) state_nxt = ST_HSTART;
            ST_HSTART:   begin HUFF_start = 1'b1; state_nxt = ST_HWAIT_LO; end
            ST_HWAIT_LO: if (!HUFF_done) state_nxt = ST_HWAIT_HI;
            ST_HWAIT_HI: if (HUFF_done) state_nxt = ST_MSTART;
            ST_MSTART:   begin MAC_start = 1'b1; state_nxt = ST_MWAIT; end
            ST_MWAIT:    if (last_accept) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // Samples-per-granule counter, granule parity and completed-frame counter.
    always_ff @(posedge MAC_clock or negedge global_rst_n) begin
        if (!global_rst_n) begin
            smp_cnt     <= '0;
            gr          <= 1'b0;
            frame_count <= '0;
        end else if (accept) begin
            smp_cnt <= last_accept ? '0 : smp_cnt + 1'b1;
            if (last_accept) begin
                gr <= ~gr;
                if (gr) frame_count <= frame_count + 16'd1;
            end
        end
    end

    // Register accepted MAC samples and present them to the PCM RAM one cycle later.
    always_ff @(posedge MAC_clock or negedge global_rst_n) begin
        if (!global_rst_n) begin
            CH0_PCM_RAM_we         <= 1'b0;
            CH0_PCM_RAM_write_data <= '0;
            CH1_PCM_RAM_write_data <= '0;
            PCM_RAM_address        <= '0;
            wr_ptr                 <= '0;
        end else begin
            CH0_PCM_RAM_we <= accept;
            if (accept) begin
                CH0_PCM_RAM_write_data <= MAC_ch0_data;
                CH1_PCM_RAM_write_data <= MAC_ch1_data;
                PCM_RAM_address        <= wr_ptr;
                wr_ptr                 <= wr_ptr + 1'b1;
            end
        end
    end

    // Local copy of the stereo buffer used for playout; contents need no reset.
    always_ff @(posedge MAC_clock) begin
        if (CH0_PCM_RAM_we) pcm_mem[PCM_RAM_address] <= {CH0_PCM_RAM_write_data, CH1_PCM_RAM_write_data};
    end

    // Two-flop synchroniser plus previous-value flop for rising-edge detection of sample_clk.
    always_ff @(posedge MAC_clock or negedge global_rst_n) begin
        if (!global_rst_n) begin
            s_meta <= 1'b0;
            s_sync <= 1'b0;
            s_prev <= 1'b0;
        end else begin
            s_meta <= sample_clk;
            s_sync <= s_meta;
            s_prev <= s_sync;
        end
    end

    // Playout: each tick emits the oldest sample, or silence plus an underrun pulse when empty.
    always_ff @(posedge MAC_clock or negedge global_rst_n) begin
        if (!global_rst_n) begin
            pcm_left   <= '0;
            pcm_right  <= '0;
            pcm_strobe <= 1'b0;
            underrun   <= 1'b0;
            rd_ptr     <= '0;
        end else begin
            pcm_strobe <= rd_fire;
            underrun   <= tick && (count == '0);
            if (rd_fire) begin
                pcm_left  <= pcm_mem[rd_ptr][31:16];
                pcm_right <= pcm_mem[rd_ptr][15:0];
                rd_ptr    <= rd_ptr + 1'b1;
            end else if (tick) begin
                pcm_left  <= '0;
                pcm_right <= '0;
            end
        end
    end

    // Occupancy: bumps when a sample lands in the buffer, drops when one is played.
    always_ff @(posedge MAC_clock or negedge global_rst_n) begin
        if (!global_rst_n) begin
            count <= '0;
        end else begin
            case ({CH0_PCM_RAM_we, rd_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_mp3_decoder_top.sv
module tb_mp3_decoder_top;
    localparam int DEPTH     = 2048;
    localparam int GRS       = 576;
    localparam int START_MAX = DEPTH - GRS;

    typedef struct packed {
        logic        und;
        logic [15:0] l;
        logic [15:0] r;
    } pb_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        bit_clk;
    logic        module_en = 1'b1;
    logic        sample_clk = 1'b0;
    logic        HUFF_done = 1'b1;
    logic        MAC_valid = 1'b0;
    logic [15:0] mac_l = '0, mac_r = '0;
    logic        HUFF_start, MAC_start, we, pcm_strobe, underrun;
    logic [15:0] wd0, wd1, pcm_left, pcm_right, frame_count;
    logic [10:0] addr;

    always #5 clk = ~clk;
    assign bit_clk = clk;

    mp3_decoder_top #(.PCM_DEPTH(DEPTH), .GR_SAMPLES(GRS)) dut (
        .MASTER_CLOCK_I(clk), .global_rst_n(rst_n), .AC97_BIT_CLOCK_I(bit_clk),
        .module_en(module_en), .sample_clk(sample_clk),
        .HUFF_start(HUFF_start), .HUFF_done(HUFF_done), .MAC_start(MAC_start),
        .MAC_valid(MAC_valid), .MAC_ch0_data(mac_l), .MAC_ch1_data(mac_r),
        .CH0_PCM_RAM_we(we), .CH0_PCM_RAM_write_data(wd0), .CH1_PCM_RAM_write_data(wd1),
        .PCM_RAM_address(addr), .pcm_left(pcm_left), .pcm_right(pcm_right),
        .pcm_strobe(pcm_strobe), .underrun(underrun), .frame_count(frame_count)
    );

    int checks = 0, errors = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Asynchronous sample-rate clock, 37 time units per period.
    bit sclk_run = 1'b0;
    int ticks_gen = 0;
    initial forever begin
        if (sclk_run) begin
            #18 sample_clk = 1'b1;
            ticks_gen++;
            #19 sample_clk = 1'b0;
        end else begin
            #5;
        end
    end

    // Observation logs and counters filled from the DUT outputs.
    logic [10:0] wa_q[$];
    logic [15:0] wl_q[$], wr_q[$];
    pb_t         pb_q[$];
    int writes = 0, played = 0, underruns = 0, bad_underrun = 0, both_pulse = 0;
    int huff_hi = 0, mac_hi = 0;
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (HUFF_start) huff_hi++;
            if (MAC_start) mac_hi++;
            if (we) begin
                wa_q.push_back(addr); wl_q.push_back(wd0); wr_q.push_back(wd1);
                writes++;
            end
            if (pcm_strobe && underrun) both_pulse++;
            if (pcm_strobe) begin
                pb_q.push_back({1'b0, pcm_left, pcm_right});
                played++;
            end
            if (underrun) begin
                pb_q.push_back({1'b1, pcm_left, pcm_right});
                underruns++;
                if (writes > played + 2) bad_underrun++;
            end
        end
    end

    // Huffman core model: busy 3 cycles after start, idle again 50 cycles later.
    int huff_starts = 0, bad_occ = 0, done_rise_cyc = 0;
    initial forever begin
        @(negedge clk);
        if (rst_n && HUFF_start) begin
            huff_starts++;
            if (writes - played > START_MAX) bad_occ++;
            repeat (3) @(negedge clk);
            HUFF_done = 1'b0;
            repeat (50) @(negedge clk);
            HUFF_done = 1'b1;
            done_rise_cyc = cyc;
        end
    end

    // MAC model: 576 samples (k, -k) with random gaps, k running across granules,
    // followed by a stray strobe that must be ignored outside the capture window.
    int mac_done = 0, smp_in_gr = 0, mac_delay_bad = 0, src_k = 0;
    int first_mac_delay = -1, huff_at_first_mac = -1;
    bit mac_active = 1'b0;
    initial forever begin
        @(negedge clk);
        if (rst_n && MAC_start) begin
            if (first_mac_delay < 0) begin
                first_mac_delay   = cyc - done_rise_cyc;
                huff_at_first_mac = huff_starts;
            end
            if (cyc - done_rise_cyc != 1) mac_delay_bad++;
            mac_active = 1'b1;
            @(negedge clk);
            for (int i = 0; i < GRS; i++) begin
                int gap;
                gap = int'($urandom_range(0, 2));
                if (gap > 0) begin
                    MAC_valid = 1'b0;
                    repeat (gap) @(negedge clk);
                end
                MAC_valid = 1'b1;
                mac_l = 16'(src_k);
                mac_r = 16'(-src_k);
                src_k++;
                smp_in_gr = i + 1;
                @(negedge clk);
            end
            mac_active = 1'b0;
            mac_done++;
            mac_l = 16'h7777;
            mac_r = 16'h7777;
            repeat (2) @(negedge clk);
            MAC_valid = 1'b0;
        end
    end

    task automatic test_reset();
        logic [15:0] obs[11];
        string       nm[11];
        #1 rst_n = 1'b0;
        repeat (100) @(negedge clk);
        obs = '{16'(HUFF_start), 16'(MAC_start), 16'(we), wd0, wd1, 16'(addr),
                pcm_left, pcm_right, 16'(pcm_strobe), 16'(underrun), frame_count};
        nm  = '{"huff_start", "mac_start", "we", "wdata0", "wdata1", "address",
                "pcm_left", "pcm_right", "pcm_strobe", "underrun", "frame_count"};
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (obs[i] !== 16'd0) begin
                errors++;
                $display("FAIL reset_%s got %0h want 0", nm[i], obs[i]);
            end
        end
        rst_n = 1'b1;
        sclk_run = 1'b1;
    endtask

    task automatic test_first_granule();
        int t = 0;
        while (mac_done < 1 && t < 4000) begin @(negedge clk); t++; end
        checks++;
        if (mac_done < 1) begin errors++; $display("FAIL first_granule_timeout got %0d granules want 1", mac_done); end
        repeat (2) @(negedge clk);
        checks++;
        if (huff_at_first_mac != 1) begin errors++; $display("FAIL huff_start_count got %0d want 1", huff_at_first_mac); end
        checks++;
        if (first_mac_delay != 1) begin errors++; $display("FAIL mac_start_delay got %0d want 1", first_mac_delay); end
        checks++;
        if (writes != GRS) begin errors++; $display("FAIL first_granule_writes got %0d want %0d", writes, GRS); end
        checks++;
        if (wa_q.size() > 0 && wa_q[wa_q.size()-1] !== 11'd575) begin
            errors++; $display("FAIL first_granule_last_addr got %0d want 575", wa_q[wa_q.size()-1]);
        end
    endtask

    task automatic test_frame_and_enable_hold();
        int t = 0;
        while (frame_count !== 16'd1 && t < 4000) begin @(negedge clk); t++; end
        module_en = 1'b0;
        checks++;
        if (frame_count !== 16'd1) begin errors++; $display("FAIL frame_timeout got %0d want 1", frame_count); end
        repeat (2) @(negedge clk);
        checks++;
        if (mac_done != 2) begin errors++; $display("FAIL frame_after_two got %0d granules want 2", mac_done); end
        repeat (200) @(negedge clk);
        checks++;
        if (huff_starts != 2 || huff_hi != 2) begin
            errors++; $display("FAIL enable_hold got %0d/%0d starts want 2", huff_starts, huff_hi);
        end
    endtask

    task automatic test_playback();
        int t = 0, j = 0, bad_val = 0, bad_zero = 0;
        while (played != writes && t < 8000) begin @(negedge clk); t++; end
        sclk_run = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (played != 2 * GRS) begin errors++; $display("FAIL drain got %0d played want %0d", played, 2 * GRS); end
        checks++;
        if (ticks_gen != played + underruns) begin
            errors++; $display("FAIL tick_count got %0d outputs want %0d", played + underruns, ticks_gen);
        end
        checks++;
        if (underruns == 0 || !pb_q[0].und) begin errors++; $display("FAIL initial_underrun got %0d want >0", underruns); end
        foreach (pb_q[i]) begin
            if (pb_q[i].und) begin
                if (pb_q[i].l !== 16'd0 || pb_q[i].r !== 16'd0) bad_zero++;
            end else begin
                if (pb_q[i].l !== 16'(j) || pb_q[i].r !== 16'(-j)) bad_val++;
                j++;
            end
        end
        checks++;
        if (bad_val != 0) begin errors++; $display("FAIL playback_order got %0d bad samples want 0", bad_val); end
        checks++;
        if (bad_zero != 0) begin errors++; $display("FAIL underrun_silence got %0d nonzero want 0", bad_zero); end
    endtask

    task automatic test_overflow();
        int t = 0;
        module_en = 1'b1;
        while (mac_done < 5 && t < 6000) begin @(negedge clk); t++; end
        repeat (1500) @(negedge clk);
        checks++;
        if (huff_starts != 5) begin errors++; $display("FAIL full_buffer_stall got %0d starts want 5", huff_starts); end
        checks++;
        if (writes != 5 * GRS) begin errors++; $display("FAIL full_buffer_writes got %0d want %0d", writes, 5 * GRS); end
        checks++;
        if (frame_count !== 16'd2) begin errors++; $display("FAIL frame_after_four got %0d want 2", frame_count); end
        checks++;
        if (wa_q.size() > 0 && wa_q[wa_q.size()-1] !== 11'((5 * GRS - 1) % DEPTH)) begin
            errors++; $display("FAIL wrap_addr got %0d want %0d", wa_q[wa_q.size()-1], (5 * GRS - 1) % DEPTH);
        end
        sclk_run = 1'b1;
        t = 0;
        while (huff_starts < 6 && t < 4000) begin @(negedge clk); t++; end
        checks++;
        if (huff_starts != 6) begin errors++; $display("FAIL resume_after_room got %0d starts want 6", huff_starts); end
    endtask

    task automatic test_enable_mid_mwait();
        int t = 0;
        while (!(mac_active && smp_in_gr >= 100) && t < 3000) begin @(negedge clk); t++; end
        module_en = 1'b0;
        t = 0;
        while (mac_done < 6 && t < 3000) begin @(negedge clk); t++; end
        repeat (2) @(negedge clk);
        checks++;
        if (writes != 6 * GRS) begin errors++; $display("FAIL granule_completes got %0d writes want %0d", writes, 6 * GRS); end
        repeat (300) @(negedge clk);
        checks++;
        if (huff_starts != 6) begin errors++; $display("FAIL disabled_no_start got %0d starts want 6", huff_starts); end
        module_en = 1'b1;
        t = 0;
        while (mac_done < 7 && t < 8000) begin @(negedge clk); t++; end
        repeat (2) @(negedge clk);
        checks++;
        if (huff_starts != 7 || frame_count !== 16'd3) begin
            errors++; $display("FAIL reenable got %0d starts frame %0d want 7 frame 3", huff_starts, frame_count);
        end
    endtask

    task automatic test_final_integrity();
        int t = 0, bad_w = 0, bad_p = 0, j = 0;
        module_en = 1'b0;
        while (played != writes && t < 20000) begin @(negedge clk); t++; end
        sclk_run = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (played != 7 * GRS) begin errors++; $display("FAIL final_drain got %0d played want %0d", played, 7 * GRS); end
        checks++;
        if (ticks_gen != played + underruns) begin
            errors++; $display("FAIL final_tick_count got %0d outputs want %0d", played + underruns, ticks_gen);
        end
        checks++;
        if (bad_underrun != 0 || both_pulse != 0) begin
            errors++; $display("FAIL spurious_underrun got %0d/%0d want 0/0", bad_underrun, both_pulse);
        end
        checks++;
        if (bad_occ != 0) begin errors++; $display("FAIL start_without_room got %0d want 0", bad_occ); end
        checks++;
        if (mac_delay_bad != 0 || mac_hi != mac_done || huff_hi != huff_starts) begin
            errors++; $display("FAIL start_pulses got delay_bad %0d mac %0d/%0d huff %0d/%0d want 0 and equal",
                               mac_delay_bad, mac_hi, mac_done, huff_hi, huff_starts);
        end
        foreach (wa_q[i]) begin
            if (wa_q[i] !== 11'(i % DEPTH) || wl_q[i] !== 16'(i) || wr_q[i] !== 16'(-i)) bad_w++;
        end
        checks++;
        if (bad_w != 0) begin errors++; $display("FAIL write_stream got %0d bad entries want 0", bad_w); end
        foreach (pb_q[i]) begin
            if (!pb_q[i].und) begin
                if (pb_q[i].l !== 16'(j) || pb_q[i].r !== 16'(-j)) bad_p++;
                j++;
            end
        end
        checks++;
        if (bad_p != 0) begin errors++; $display("FAIL final_playback got %0d bad samples want 0", bad_p); end
    endtask

    initial begin
        test_reset();
        test_first_granule();
        test_frame_and_enable_hold();
        test_playback();
        test_overflow();
        test_enable_mid_mwait();
        test_final_integrity();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
